// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32 core. EX reads and writes it with
// write/set/clear ops. The trap controller drives trap entry and MRET.
// It holds two inhibitable CNT_W-bit counters and a registered mip.
// It also generates interrupt-pending and illegal-access flags.
module csr_file #(
  parameter int          CNT_W     = 64,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] HART_ID   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_addr_i,
  input  logic [1:0]  csr_op_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        retire_i,
  input  logic        trap_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  input  logic        mret_i,
  input  logic        timer_irq_i,
  input  logic        ext_irq_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        irq_pending_o,
  output logic [31:0] irq_cause_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MCOUNTIN = 12'h320;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRETH= 12'hB82;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_INSTRET  = 12'hC02;
  localparam logic [11:0] A_CYCLEH   = 12'hC80;
  localparam logic [11:0] A_INSTRETH = 12'hC82;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  // Architectural state
  logic                  mstatus_mie_reg;
  logic                  mstatus_mpie_reg;
  logic [31:0]           mie_reg;
  logic [31:0]           mtvec_reg;
  logic                  inhibit_cy_reg;
  logic                  inhibit_ir_reg;
  logic [31:0]           mscratch_reg;
  logic [31:0]           mepc_reg;
  logic [31:0]           mcause_reg;
  logic                  mtip_reg;
  logic                  meip_reg;
  // Index 0 is mcycle and index 1 is minstret.
  logic [1:0][CNT_W-1:0] cnt_reg;

  logic [31:0]      cnt_lo [2];
  logic [31:0]      cnt_hi [2];
  logic [31:0]      mip_vec;
  logic [31:0]      old_val;
  logic [31:0]      new_val;
  logic             implemented;
  logic             read_only;
  logic             write_en;
  logic [1:0]       wr_lo;
  logic [1:0]       wr_hi;
  logic [1:0]       inc_en;

  assign mip_vec = {20'b0, meip_reg, 3'b0, mtip_reg, 7'b0};

  // Counter halves as 32-bit views; bits at and above CNT_W read 0.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt_view
      assign cnt_lo[gi] = cnt_reg[gi][31:0];
      assign cnt_hi[gi] = 32'(cnt_reg[gi][CNT_W-1:32]);
    end
  endgenerate

  // Address decode: read value, implemented and read-only flags
  always_comb begin
    old_val     = 32'h0;
    implemented = 1'b1;
    read_only   = 1'b0;
    case (csr_addr_i)
      A_MSTATUS:   old_val = {19'b0, 2'b11, 3'b0, mstatus_mpie_reg, 3'b0, mstatus_mie_reg, 3'b0};
      A_MIE:       old_val = mie_reg;
      A_MTVEC:     old_val = mtvec_reg;
      A_MCOUNTIN:  old_val = {29'b0, inhibit_ir_reg, 1'b0, inhibit_cy_reg};
      A_MSCRATCH:  old_val = mscratch_reg;
      A_MEPC:      old_val = mepc_reg;
      A_MCAUSE:    old_val = mcause_reg;
      A_MIP:       begin old_val = mip_vec;   read_only = 1'b1; end
      A_MCYCLE:    old_val = cnt_lo[0];
      A_MINSTRET:  old_val = cnt_lo[1];
      A_MCYCLEH:   old_val = cnt_hi[0];
      A_MINSTRETH: old_val = cnt_hi[1];
      A_CYCLE:     begin old_val = cnt_lo[0]; read_only = 1'b1; end
      A_INSTRET:   begin old_val = cnt_lo[1]; read_only = 1'b1; end
      A_CYCLEH:    begin old_val = cnt_hi[0]; read_only = 1'b1; end
      A_INSTRETH:  begin old_val = cnt_hi[1]; read_only = 1'b1; end
      A_MHARTID:   begin old_val = HART_ID;   read_only = 1'b1; end
      default:     implemented = 1'b0;
    endcase
  end

  // Legality, read-modify-write value and commit qualification
  always_comb begin
    csr_illegal_o = 1'b0;
    if (csr_op_i != OP_NONE) begin
      if (!implemented) begin
        csr_illegal_o = 1'b1;
      end else if (read_only && (csr_op_i == OP_WRITE || csr_wdata_i != 32'h0)) begin
        csr_illegal_o = 1'b1;
      end
    end
    case (csr_op_i)
      OP_WRITE: new_val = csr_wdata_i;
      OP_SET:   new_val = old_val | csr_wdata_i;
      OP_CLEAR: new_val = old_val & ~csr_wdata_i;
      default:  new_val = old_val;
    endcase
    write_en = (csr_op_i != OP_NONE) && !csr_illegal_o && !trap_i && !mret_i;
  end

  // Per-counter write strobes and increment enables
  always_comb begin
    wr_lo[0]  = write_en && (csr_addr_i == A_MCYCLE);
    wr_hi[0]  = write_en && (csr_addr_i == A_MCYCLEH);
    wr_lo[1]  = write_en && (csr_addr_i == A_MINSTRET);
    wr_hi[1]  = write_en && (csr_addr_i == A_MINSTRETH);
    inc_en[0] = !inhibit_cy_reg;
    inc_en[1] = retire_i && !inhibit_ir_reg;
  end

  // Counters: a write to one half freezes the counter for that cycle.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      // Counter update: reset, half write, or increment
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (wr_lo[gi]) begin
          cnt_reg[gi][31:0] <= new_val;
        end else if (wr_hi[gi]) begin
          cnt_reg[gi][CNT_W-1:32] <= new_val[CNT_W-33:0];
        end else if (inc_en[gi]) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  // mstatus interrupt-enable stack: trap beats MRET, both beat CSR writes
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
    end else if (trap_i) begin
      mstatus_mpie_reg <= mstatus_mie_reg;
      mstatus_mie_reg  <= 1'b0;
    end else if (mret_i) begin
      mstatus_mie_reg  <= mstatus_mpie_reg;
      mstatus_mpie_reg <= 1'b1;
    end else if (write_en && csr_addr_i == A_MSTATUS) begin
      mstatus_mie_reg  <= new_val[3];
      mstatus_mpie_reg <= new_val[7];
    end
  end

  // Trap-captured registers: mepc and mcause
  always_ff @(posedge clk) begin
    if (rst) begin
      mepc_reg   <= 32'h0;
      mcause_reg <= 32'h0;
    end else if (trap_i) begin
      mepc_reg   <= {trap_pc_i[31:2], 2'b00};
      mcause_reg <= trap_cause_i;
    end else if (write_en) begin
      if (csr_addr_i == A_MEPC)   mepc_reg   <= {new_val[31:2], 2'b00};
      if (csr_addr_i == A_MCAUSE) mcause_reg <= new_val;
    end
  end

  // Plain software-written registers with their field masks
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_reg        <= 32'h0;
      mtvec_reg      <= MTVEC_RST;
      inhibit_cy_reg <= 1'b0;
      inhibit_ir_reg <= 1'b0;
      mscratch_reg   <= 32'h0;
    end else if (write_en) begin
      case (csr_addr_i)
        A_MIE:      mie_reg   <= new_val & MIE_MASK;
        A_MTVEC:    mtvec_reg <= {new_val[31:2], 1'b0, new_val[0]};
        A_MCOUNTIN: begin
          inhibit_cy_reg <= new_val[0];
          inhibit_ir_reg <= new_val[2];
        end
        A_MSCRATCH: mscratch_reg <= new_val;
        default: ;
      endcase
    end
  end

  // mip tracks the interrupt lines through one flop each
  always_ff @(posedge clk) begin
    if (rst) begin
      mtip_reg <= 1'b0;
      meip_reg <= 1'b0;
    end else begin
      mtip_reg <= timer_irq_i;
      meip_reg <= ext_irq_i;
    end
  end

  // Interrupt request and cause; external has priority over timer
  always_comb begin
    irq_pending_o = mstatus_mie_reg && (|(mie_reg & mip_vec));
    irq_cause_o   = 32'h0;
    if (meip_reg && mie_reg[11]) begin
      irq_cause_o = 32'h8000_000B;
    end else if (mtip_reg && mie_reg[7]) begin
      irq_cause_o = 32'h8000_0007;
    end
  end

  assign csr_rdata_o = old_val;
  assign mtvec_o     = mtvec_reg;
  assign mepc_o      = mepc_reg;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file. It runs directed scenarios, then
// randomized traffic. Results are compared against an architectural
// model of the CSR state.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        retire;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic        mret;
  logic        timer_irq;
  logic        ext_irq;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        irq_pending;
  logic [31:0] irq_cause;

  int n_checks = 0;
  int n_errors = 0;

  csr_file #(
    .CNT_W(64), .MTVEC_RST(32'h0000_0100), .HART_ID(32'h0000_0005)
  ) dut (
    .clk(clk), .rst(rst),
    .csr_addr_i(csr_addr), .csr_op_i(csr_op), .csr_wdata_i(csr_wdata),
    .csr_rdata_o(csr_rdata), .csr_illegal_o(csr_illegal),
    .retire_i(retire), .trap_i(trap), .trap_pc_i(trap_pc),
    .trap_cause_i(trap_cause), .mret_i(mret),
    .timer_irq_i(timer_irq), .ext_irq_i(ext_irq),
    .mtvec_o(mtvec), .mepc_o(mepc),
    .irq_pending_o(irq_pending), .irq_cause_o(irq_cause)
  );

  always #5 clk = ~clk;

  // Architectural model state
  logic [31:0] m_mstatus;   // only bits 3 (MIE) and 7 (MPIE) stored
  logic [31:0] m_mie, m_mtvec, m_inh, m_mscratch, m_mepc, m_mcause, m_mip;
  logic [63:0] m_cyc, m_ins;

  logic [11:0] addr_list [17] = '{12'h300, 12'h304, 12'h305, 12'h320, 12'h340,
    12'h341, 12'h342, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00,
    12'hC02, 12'hC80, 12'hC82, 12'hF14};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_impl(input logic [11:0] a);
    foreach (addr_list[i]) if (addr_list[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ro(input logic [11:0] a);
    return (a == 12'h344) || (a == 12'hF14) || (a >= 12'hC00 && a <= 12'hC82);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus | 32'h1800;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h320: return m_inh;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB82, 12'hC82: return m_ins[63:32];
      12'hF14: return 32'h5;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_illegal(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
    if (op == 2'b00) return 1'b0;
    if (!m_impl(a)) return 1'b1;
    return m_ro(a) && (op == 2'b01 || wd != 0);
  endfunction

  task automatic model_reset();
    m_mstatus = 0; m_mie = 0; m_mtvec = 32'h100; m_inh = 0; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_mip = 0; m_cyc = 0; m_ins = 0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_step();
    logic [31:0] old, nv;
    logic [63:0] c_next, i_next;
    bit we;
    if (rst) begin
      model_reset();
      return;
    end
    old = m_read(csr_addr);
    case (csr_op)
      2'b01: nv = csr_wdata;
      2'b10: nv = old | csr_wdata;
      2'b11: nv = old & ~csr_wdata;
      default: nv = old;
    endcase
    we = csr_op != 0 && !m_illegal(csr_addr, csr_op, csr_wdata) && !trap && !mret;

    c_next = m_cyc;
    if (we && csr_addr == 12'hB00) c_next[31:0] = nv;
    else if (we && csr_addr == 12'hB80) c_next[63:32] = nv;
    else if (!m_inh[0]) c_next = m_cyc + 1;
    i_next = m_ins;
    if (we && csr_addr == 12'hB02) i_next[31:0] = nv;
    else if (we && csr_addr == 12'hB82) i_next[63:32] = nv;
    else if (retire && !m_inh[2]) i_next = m_ins + 1;

    if (trap) begin
      m_mepc    = trap_pc & ~32'h3;
      m_mcause  = trap_cause;
      m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
    end else if (mret) begin
      m_mstatus = m_mstatus[7] ? 32'h88 : 32'h80;
    end else if (we) begin
      case (csr_addr)
        12'h300: m_mstatus  = nv & 32'h88;
        12'h304: m_mie      = nv & 32'h888;
        12'h305: m_mtvec    = nv & ~32'h2;
        12'h320: m_inh      = nv & 32'h5;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc     = nv & ~32'h3;
        12'h342: m_mcause   = nv;
        default: ;
      endcase
    end
    m_cyc = c_next;
    m_ins = i_next;
    m_mip = (ext_irq ? 32'h800 : 32'h0) | (timer_irq ? 32'h80 : 32'h0);
  endtask

  function automatic logic [31:0] m_cause_val();
    if (m_mip[11] && m_mie[11]) return 32'h8000_000B;
    if (m_mip[7] && m_mie[7]) return 32'h8000_0007;
    return 32'h0;
  endfunction

  // One transaction: compare outputs mid-cycle, then advance the model on the edge.
  task automatic cyc();
    @(negedge clk);
    $display("txn t=%0t rst=%0b addr=%h op=%0d wd=%h rd=%h ill=%0b trap=%0b mret=%0b",
             $time, rst, csr_addr, csr_op, csr_wdata, csr_rdata, csr_illegal, trap, mret);
    if (!rst) begin
      check("rdata", csr_rdata, m_read(csr_addr));
      check("illegal", 32'(csr_illegal), 32'(m_illegal(csr_addr, csr_op, csr_wdata)));
      check("irq_pending", 32'(irq_pending), 32'(m_mstatus[3] && |(m_mie & m_mip)));
      check("irq_cause", irq_cause, m_cause_val());
      check("mtvec_o", mtvec, m_mtvec);
      check("mepc_o", mepc, m_mepc);
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    csr_addr = 12'h0; csr_op = 2'b00; csr_wdata = 0; retire = 0;
    trap = 0; trap_pc = 0; trap_cause = 0; mret = 0;
  endtask

  task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
    csr_addr = a; csr_op = op; csr_wdata = wd;
    cyc();
    idle_inputs();
  endtask

  // Look at a CSR with no op, between edges.
  task automatic peek(input logic [11:0] a);
    csr_addr = a; csr_op = 2'b00; csr_wdata = 0;
    #1;
  endtask

  initial begin
    idle_inputs();
    timer_irq = 0; ext_irq = 0;
    model_reset();
    rst = 1;
    @(posedge clk); #1;
    cyc(); cyc();
    rst = 0;

    // Reset values
    check("rst_mtvec", mtvec, 32'h100);
    peek(12'h300); check("rst_mstatus", csr_rdata, 32'h1800);
    peek(12'hB00); check("rst_mcycle", csr_rdata, 32'h0);
    check("rst_irq_cause", irq_cause, 32'h0);
    cyc();
    peek(12'hB00); check("mcycle_after_rst", csr_rdata, 32'h1);

    // Read-modify-write on mscratch
    csr(12'h340, 2'b01, 32'hDEAD_BEEF);
    peek(12'h340); check("rw_mscratch", csr_rdata, 32'hDEAD_BEEF);
    csr(12'h340, 2'b10, 32'h0F);
    peek(12'h340); check("rs_mscratch", csr_rdata, 32'hDEAD_BEEF);
    csr(12'h340, 2'b11, 32'hF0);
    peek(12'h340); check("rc_mscratch", csr_rdata, 32'hDEAD_BE0F);

    // Timer interrupt
    csr(12'h300, 2'b01, 32'h8);
    csr(12'h304, 2'b01, 32'h80);
    timer_irq = 1;
    cyc();
    check("irq_pending_timer", 32'(irq_pending), 32'h1);
    check("irq_cause_timer", irq_cause, 32'h8000_0007);
    timer_irq = 0;

    // Trap entry with a concurrent mscratch write that must be dropped
    trap = 1; trap_pc = 32'h203; trap_cause = 32'h8000_0007;
    csr(12'h340, 2'b01, 32'h1);
    check("trap_mepc", mepc, 32'h200);
    check("trap_irq_pending", 32'(irq_pending), 32'h0);
    peek(12'h300); check("trap_mstatus", csr_rdata, 32'h1880);
    peek(12'h340); check("trap_mscratch", csr_rdata, 32'hDEAD_BE0F);
    peek(12'h342); check("trap_mcause", csr_rdata, 32'h8000_0007);
    mret = 1;
    cyc();
    idle_inputs();
    peek(12'h300); check("mret_mstatus", csr_rdata, 32'h1888);

    // Counter carry across halves and inhibit
    csr(12'hB00, 2'b01, 32'hFFFF_FFFF);
    csr(12'hB80, 2'b01, 32'h0);
    cyc();
    peek(12'hB80); check("mcycleh_carry", csr_rdata, 32'h1);
    csr(12'h320, 2'b01, 32'h5);
    retire = 1;
    cyc(); cyc(); cyc();
    retire = 0;
    peek(12'hB00); check("mcycle_frozen", csr_rdata, 32'h0000_0001);
    peek(12'hB02); check("minstret_frozen", csr_rdata, m_ins[31:0]);
    csr(12'h320, 2'b01, 32'h0);

    // Illegal accesses
    csr_addr = 12'hC00; csr_op = 2'b01; csr_wdata = 32'h5; #1;
    check("ill_cycle_rw", 32'(csr_illegal), 32'h1);
    cyc();
    csr_addr = 12'hF14; csr_op = 2'b10; csr_wdata = 32'h0; #1;
    check("ill_hartid_rs0", 32'(csr_illegal), 32'h0);
    cyc();
    csr_addr = 12'h7FF; csr_op = 2'b01; csr_wdata = 32'h1234; #1;
    check("ill_unimpl", 32'(csr_illegal), 32'h1);
    cyc();
    idle_inputs();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      csr_addr  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addr_list[$urandom_range(0, 16)];
      csr_op    = 2'($urandom);
      csr_wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      retire    = 1'($urandom);
      trap      = ($urandom_range(0, 19) == 0);
      mret      = ($urandom_range(0, 19) == 0);
      trap_pc   = $urandom;
      trap_cause= $urandom;
      timer_irq = ($urandom_range(0, 3) == 0);
      ext_irq   = ($urandom_range(0, 5) == 0);
      cyc();
    end
    rst = 0;
    idle_inputs();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
